// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative signed WIDTH x WIDTH radix-2 Booth multiplier.
// The operand pair is taken on a valid/ready handshake. The A/Q/Q_1 state then
// runs through one Booth step per cycle for WIDTH cycles. The 2*WIDTH-bit
// product is offered on a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (in_ready registered)
//   multiplicand, multiplier   signed operands M and Q
//   out_valid / out_ready      result handshake (out_valid registered)
//   product                    signed product, held while out_valid && !out_ready
//   busy                       high while a multiplication is in RUN or DONE
module booth_seq_mult #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // The Booth step datapath is fixed at 32 bits.
    if (WIDTH != 32) begin : g_bad_width
        $error("booth_seq_mult: WIDTH must be 32");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
        $error("booth_seq_mult: CNT_W too narrow to hold WIDTH");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0]   MIN_NEG     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] CORNER_PROD = {2'b01, {(2*WIDTH-2){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 q1_q, q1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 corner_q, corner_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       sum_c;
    logic [WIDTH-1:0]     next_a_c;
    logic [WIDTH-1:0]     next_q_c;
    logic                 next_q1_c;

    // One radix-2 Booth step. A is extended by one bit so that the add or
    // subtract cannot overflow before the arithmetic right shift.
    always_comb begin
        sum_c = {a_q[WIDTH-1], a_q};
        unique case ({q_q[0], q1_q})
            2'b01:   sum_c = {a_q[WIDTH-1], a_q} + {m_q[WIDTH-1], m_q};
            2'b10:   sum_c = {a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q};
            default: sum_c = {a_q[WIDTH-1], a_q};
        endcase
        next_a_c  = sum_c[WIDTH:1];
        next_q_c  = {sum_c[0], q_q[WIDTH-1:1]};
        next_q1_c = q_q[0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        q1_d     = q1_q;
        cnt_d    = cnt_q;
        corner_d = corner_q;
        prod_d   = prod_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = '0;
                    q1_d     = 1'b0;
                    cnt_d    = CNT_W'(WIDTH);
                    corner_d = (multiplicand == MIN_NEG) && (multiplier == MIN_NEG);
                    // Keep -2^(WIDTH-1) out of M, since it cannot be negated in WIDTH bits.
                    if ((multiplicand == MIN_NEG) && (multiplier != MIN_NEG)) begin
                        m_d = multiplier;
                        q_d = multiplicand;
                    end else begin
                        m_d = multiplicand;
                        q_d = multiplier;
                    end
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = next_a_c;
                q_d   = next_q_c;
                q1_d  = next_q1_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = corner_q ? CORNER_PROD : {next_a_c, next_q_c};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            q1_q        <= 1'b0;
            cnt_q       <= '0;
            corner_q    <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
            corner_q    <= corner_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = prod_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed corner cases, stall, mid-run
// reset, back-to-back throughput and randomized traffic against a longint model.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    booth_seq_mult #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-precision signed product.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return MIN_NEG;
            1:       return 32'h0000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Runs one multiplication with out_ready held high; reports handshake misbehaviour.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] p, output int lat,
                           output bit hs_bad, output bit timeout);
        int g;
        hs_bad = 1'b0; timeout = 1'b0; p = '0; lat = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; multiplicand = a; multiplier = b;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        if (!in_ready) begin timeout = 1'b1; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin timeout = 1'b1; return; end
        if (in_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
        p = product;
        @(negedge clk);
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) hs_bad = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
        end
        tests_run++;
        if (product !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_product: got %h want 0", product);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic [63:0] te [7];
        logic [63:0] p;
        int          lat;
        bit          hs_bad;
        bit          to;
        ta[0] = 32'd7;          tb[0] = 32'hFFFF_FFFD;  te[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        ta[1] = 32'h7FFF_FFFF;  tb[1] = 32'h7FFF_FFFF;  te[1] = 64'h3FFF_FFFF_0000_0001;
        ta[2] = MIN_NEG;        tb[2] = 32'd5;          te[2] = 64'hFFFF_FFFD_8000_0000;
        ta[3] = MIN_NEG;        tb[3] = MIN_NEG;        te[3] = 64'h4000_0000_0000_0000;
        ta[4] = 32'd0;          tb[4] = MIN_NEG;        te[4] = 64'h0;
        ta[5] = 32'd5;          tb[5] = MIN_NEG;        te[5] = 64'hFFFF_FFFD_8000_0000;
        ta[6] = 32'hFFFF_FFFF;  tb[6] = 32'hFFFF_FFFF;  te[6] = 64'h1;
        for (int i = 0; i < 7; i++) begin
            do_mult(ta[i], tb[i], p, lat, hs_bad, to);
            tests_run++;
            if (to || hs_bad) begin
                tests_failed++;
                $display("FAIL directed_handshake[%0d]: timeout=%b bad_flags=%b want 0/0", i, to, hs_bad);
            end
            tests_run++;
            if (p !== te[i]) begin
                tests_failed++;
                $display("FAIL directed_product[%0d] %h*%h: got %h want %h", i, ta[i], tb[i], p, te[i]);
            end
            // out_valid first seen 32 edges after the accept edge (cycle 33 counting the accept cycle).
            tests_run++;
            if (lat !== 32) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: got %0d edges want 32", i, lat);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp0;
        int          g;
        exp0 = ref_mul(32'hFFFF_FFFB, 32'd1234567);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; multiplicand = 32'hFFFF_FFFB; multiplier = 32'd1234567;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        @(negedge clk);
        // A pending pair that must be ignored until the result is taken.
        multiplicand = 32'd9; multiplier = 32'd11;
        g = 0;
        while (!out_valid && g < 100) begin @(negedge clk); g++; end
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_flags[%0d]: got out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready);
            end
            tests_run++;
            if (product !== exp0) begin
                tests_failed++;
                $display("FAIL stall_product[%0d]: got %h want %h", k, product, exp0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_next_accept: got busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        g = 0;
        while (!out_valid && g < 100) begin @(negedge clk); g++; end
        tests_run++;
        if (product !== 64'd99 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_second_product: got %h valid=%b want 63 valid=1", product, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p;
        int          lat;
        int          g;
        bit          hs_bad;
        bit          to;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; multiplicand = 32'd7; multiplier = 32'hFFFF_FFFD;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 64'h0) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: got in_ready/out_valid/busy=%b product=%h want 100 and 0",
                     {in_ready, out_valid, busy}, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_after_release: got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        g = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) g++;
        end
        tests_run++;
        if (g != 0) begin
            tests_failed++;
            $display("FAIL midrun_ghost_result: got out_valid high for %0d cycles want 0", g);
        end
        do_mult(32'd2, 32'd3, p, lat, hs_bad, to);
        tests_run++;
        if (to || hs_bad || p !== 64'd6) begin
            tests_failed++;
            $display("FAIL midrun_fresh_2x3: got %h timeout=%b bad=%b want 6", p, to, hs_bad);
        end
    endtask

    task automatic test_back_to_back();
        int          acc0;
        int          acc1;
        int          g;
        logic [63:0] p0;
        logic [63:0] p1;
        out_ready = 1'b1;
        p0 = '0; p1 = '0;
        @(negedge clk);
        in_valid = 1'b1; multiplicand = 32'd12345; multiplier = 32'hFFFF_FF00;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        acc0 = cyc;
        @(negedge clk);
        multiplicand = 32'h0001_0000; multiplier = 32'h0001_0000;
        g = 0;
        while (!in_ready && g < 100) begin
            if (out_valid) p0 = product;
            @(negedge clk);
            g++;
        end
        acc1 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 100) begin @(negedge clk); g++; end
        p1 = product;
        @(negedge clk);
        tests_run++;
        if (acc1 - acc0 !== 34) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d cycles between accepts want 34", acc1 - acc0);
        end
        tests_run++;
        if (p0 !== ref_mul(32'd12345, 32'hFFFF_FF00)) begin
            tests_failed++;
            $display("FAIL b2b_first_product: got %h want %h", p0, ref_mul(32'd12345, 32'hFFFF_FF00));
        end
        tests_run++;
        if (p1 !== 64'h0000_0001_0000_0000) begin
            tests_failed++;
            $display("FAIL b2b_second_product: got %h want 0000000100000000", p1);
        end
    endtask

    task automatic test_random(input int n);
        logic [63:0] exp_q [$];
        fork
            begin : driver
                logic [31:0] a;
                logic [31:0] b;
                int          g;
                bit          sent;
                for (int i = 0; i < n; i++) begin
                    a = pick_operand();
                    b = pick_operand();
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                    g = 0;
                    sent = 1'b0;
                    while (!sent && g < 200) begin
                        @(negedge clk);
                        in_valid = 1'b1;
                        if (in_ready) begin
                            multiplicand = a; multiplier = b;
                            exp_q.push_back(ref_mul(a, b));
                            sent = 1'b1;
                        end else begin
                            // Junk operands while busy must not disturb the running product.
                            multiplicand = 32'($urandom); multiplier = 32'($urandom);
                            g++;
                        end
                    end
                    if (!sent) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL random_accept_timeout: got no in_ready in 200 cycles want accept");
                        i = n;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : monitor
                int          got;
                int          waited;
                bit          held_v;
                logic [63:0] held;
                logic [63:0] e;
                got = 0; waited = 0; held_v = 1'b0; held = '0;
                while (got < n && waited < 90000) begin
                    @(negedge clk);
                    waited++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid) begin
                        if (held_v) begin
                            tests_run++;
                            if (product !== held) begin
                                tests_failed++;
                                $display("FAIL random_stall_stable: got %h want %h", product, held);
                            end
                        end
                        if (out_ready) begin
                            tests_run++;
                            if (exp_q.size() == 0) begin
                                tests_failed++;
                                $display("FAIL random_duplicate: got product %h want no result", product);
                            end else begin
                                e = exp_q.pop_front();
                                if (product !== e) begin
                                    tests_failed++;
                                    $display("FAIL random_product[%0d]: got %h want %h", got, product, e);
                                end
                            end
                            got++;
                            held_v = 1'b0;
                        end else begin
                            held   = product;
                            held_v = 1'b1;
                        end
                    end
                end
                tests_run++;
                if (got != n) begin
                    tests_failed++;
                    $display("FAIL random_lost: got %0d results want %0d", got, n);
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_leftover: got %0d unreturned results want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_random(1200);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running at 1ms want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
